// File: rtl/id_stage_pkg.sv
// Shared decode definitions: opcode encoding and instruction field positions.
package id_stage_pkg;

   typedef enum logic [1:0] {
      OP_MOV = 2'b00,
      OP_ADD = 2'b01,
      OP_LDI = 2'b10,
      OP_JMP = 2'b11
   } opcode_t;

   // Instruction layout: op[7:6] rd[5:3] rs/imm[2:0]
   localparam int OP_MSB = 7;
   localparam int OP_LSB = 6;
   localparam int RD_MSB = 5;
   localparam int RD_LSB = 3;
   localparam int RS_MSB = 2;
   localparam int RS_LSB = 0;

endpackage

// File: rtl/id_stage_regfile.sv
// Register file: NREG entries, one write port, two combinational read ports,
// synchronous active-low clear of every entry.
module id_stage_regfile #(
   parameter  int DATA_W = 8,
   parameter  int NREG   = 8,
   localparam int AW     = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr_a,
   input  logic [AW-1:0]     i_raddr_b,
   output logic [DATA_W-1:0] o_rdata_a,
   output logic [DATA_W-1:0] o_rdata_b
);

   logic [DATA_W-1:0] r_mem [NREG];

   // Clear all entries on reset; otherwise perform the single write (r0 included)
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, operand forwarding (EX over WB over regfile)
// and the ID/EX pipeline register.
module id_stage
   import id_stage_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int NREG   = 8,
   localparam int AW     = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] instruc_code,
   input  logic              ex_we,
   input  logic [AW-1:0]     ex_rd,
   input  logic [DATA_W-1:0] ex_result,
   input  logic              wb_we,
   input  logic [AW-1:0]     wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic [1:0]        idex_op,
   output logic [AW-1:0]     idex_rd,
   output logic [DATA_W-1:0] idex_a,
   output logic [DATA_W-1:0] idex_b,
   output logic              idex_we
);

   logic [DATA_W-1:0] r_ifid;
   logic              r_ifid_valid;
   opcode_t           r_idex_op;
   logic [AW-1:0]     r_idex_rd;
   logic [DATA_W-1:0] r_idex_a;
   logic [DATA_W-1:0] r_idex_b;
   logic              r_idex_we;

   opcode_t           w_op;
   logic [AW-1:0]     w_rd;
   logic [AW-1:0]     w_rs;
   logic [DATA_W-1:0] w_imm_ext;
   logic [DATA_W-1:0] w_rf_a;
   logic [DATA_W-1:0] w_rf_b;
   logic [DATA_W-1:0] w_val_a;
   logic [DATA_W-1:0] w_val_b;

   assign w_op      = opcode_t'(r_ifid[OP_MSB:OP_LSB]);
   assign w_rd      = r_ifid[RD_MSB:RD_LSB];
   assign w_rs      = r_ifid[RS_MSB:RS_LSB];
   assign w_imm_ext = {{(DATA_W-3){1'b0}}, r_ifid[RS_MSB:RS_LSB]};

   id_stage_regfile #(
      .DATA_W (DATA_W),
      .NREG   (NREG)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .i_we      (wb_we),
      .i_waddr   (wb_rd),
      .i_wdata   (wb_data),
      .i_raddr_a (w_rd),
      .i_raddr_b (w_rs),
      .o_rdata_a (w_rf_a),
      .o_rdata_b (w_rf_b)
   );

   // IF/ID capture; the valid bit keeps the cleared word from looking like a real MOV r0,r0
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ifid       <= '0;
         r_ifid_valid <= 1'b0;
      end else begin
         r_ifid       <= instruc_code;
         r_ifid_valid <= 1'b1;
      end
   end

   // Operand A forwarding for rd: EX result wins over WB data, WB over regfile
   always_comb begin
      w_val_a = w_rf_a;
      if (wb_we && (wb_rd == w_rd)) w_val_a = wb_data;
      if (ex_we && (ex_rd == w_rd)) w_val_a = ex_result;
   end

   // Operand B forwarding for rs, resolved independently of A
   always_comb begin
      w_val_b = w_rf_b;
      if (wb_we && (wb_rd == w_rs)) w_val_b = wb_data;
      if (ex_we && (ex_rd == w_rs)) w_val_b = ex_result;
   end

   // ID/EX register; JMP and the post-reset invalid slot both leave as bubbles
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_idex_op <= OP_MOV;
         r_idex_rd <= '0;
         r_idex_a  <= '0;
         r_idex_b  <= '0;
         r_idex_we <= 1'b0;
      end else begin
         r_idex_op <= r_ifid_valid ? w_op : OP_MOV;
         if (r_ifid_valid && (w_op != OP_JMP)) begin
            r_idex_rd <= w_rd;
            r_idex_a  <= w_val_a;
            r_idex_b  <= (w_op == OP_LDI) ? w_imm_ext : w_val_b;
            r_idex_we <= 1'b1;
         end else begin
            r_idex_rd <= '0;
            r_idex_a  <= '0;
            r_idex_b  <= '0;
            r_idex_we <= 1'b0;
         end
      end
   end

   assign idex_op = r_idex_op;
   assign idex_rd = r_idex_rd;
   assign idex_a  = r_idex_a;
   assign idex_b  = r_idex_b;
   assign idex_we = r_idex_we;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: the driver predicts each edge's ID/EX contents
// from an instruction-level model and queues them; the monitor checks after every edge.
module tb_id_stage;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] instruc_code;
   logic       ex_we;
   logic [2:0] ex_rd;
   logic [7:0] ex_result;
   logic       wb_we;
   logic [2:0] wb_rd;
   logic [7:0] wb_data;
   logic [1:0] idex_op;
   logic [2:0] idex_rd;
   logic [7:0] idex_a;
   logic [7:0] idex_b;
   logic       idex_we;

   typedef struct {
      logic [1:0] op;
      logic [2:0] rd;
      logic [7:0] a;
      logic [7:0] b;
      logic       we;
   } exp_t;

   exp_t       sb_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   bit         drive_done = 1'b0;

   // Architectural model: register contents and the instruction waiting in decode
   logic [7:0] m_regs [8];
   logic [7:0] m_pend;
   bit         m_pend_valid;

   always #5 clk = ~clk;

   id_stage dut (
      .clk          (clk),
      .rst          (rst),
      .instruc_code (instruc_code),
      .ex_we        (ex_we),
      .ex_rd        (ex_rd),
      .ex_result    (ex_result),
      .wb_we        (wb_we),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .idex_op      (idex_op),
      .idex_rd      (idex_rd),
      .idex_a       (idex_a),
      .idex_b       (idex_b),
      .idex_we      (idex_we)
   );

   // Value of register r as seen by decode in the current cycle
   function automatic logic [7:0] value_of(input logic [2:0] r);
      if (ex_we && ex_rd == r) return ex_result;
      if (wb_we && wb_rd == r) return wb_data;
      return m_regs[r];
   endfunction

   // Drive one cycle of inputs and queue what the next edge must produce
   task automatic drive(input logic r, input logic [7:0] ins,
                        input logic xwe, input logic [2:0] xrd, input logic [7:0] xres,
                        input logic wwe, input logic [2:0] wrd, input logic [7:0] wdat);
      exp_t e;
      rst = r; instruc_code = ins;
      ex_we = xwe; ex_rd = xrd; ex_result = xres;
      wb_we = wwe; wb_rd = wrd; wb_data = wdat;
      e = '{op: 2'd0, rd: 3'd0, a: 8'd0, b: 8'd0, we: 1'b0};
      if (!r) begin
         for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
         m_pend = 8'h00;
         m_pend_valid = 1'b0;
      end else begin
         if (m_pend_valid) begin
            e.op = m_pend[7:6];
            if (m_pend[7:6] != 2'b11) begin
               e.rd = m_pend[5:3];
               e.a  = value_of(m_pend[5:3]);
               e.b  = (m_pend[7:6] == 2'b10) ? {5'b00000, m_pend[2:0]} : value_of(m_pend[2:0]);
               e.we = 1'b1;
            end
         end
         if (wwe) m_regs[wrd] = wdat;
         m_pend = ins;
         m_pend_valid = 1'b1;
      end
      sb_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input int txn, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL txn %0d %s: got %h expected %h", txn, name, act, exp);
      end
   endtask

   // Monitor: compare DUT outputs one time unit after every rising edge
   initial begin
      exp_t e;
      int   txn = 0;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("idex_we", txn, {7'd0, idex_we}, {7'd0, e.we});
            chk("idex_op", txn, {6'd0, idex_op}, {6'd0, e.op});
            chk("idex_rd", txn, {5'd0, idex_rd}, {5'd0, e.rd});
            chk("idex_a",  txn, idex_a, e.a);
            chk("idex_b",  txn, idex_b, e.b);
            $display("txn %0d op=%0d rd=%0d a=%h b=%h we=%0d", txn, idex_op, idex_rd, idex_a, idex_b, idex_we);
            txn++;
         end
      end
   end

   // Stimulus: directed scenarios first, then randomized traffic with occasional resets
   initial begin
      int guard;
      // reset held two cycles with a live instruction on the bus
      drive(0, 8'h5A, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
      drive(0, 8'h5A, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
      // LDI r3,#5 enters; first post-reset edge must be a bubble
      drive(1, 8'b10_011_101, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
      // MOV r1,r2 enters; LDI decoded
      drive(1, 8'b00_001_010, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
      // WB writes r2=33 while MOV r1,r2 decodes
      drive(1, 8'b00_000_000, 0, 3'd0, 8'h00, 1, 3'd2, 8'h33);
      // MOV r3,r2 enters to read r2 back from the register file
      drive(1, 8'b00_011_010, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
      // ADD r4,r4 enters
      drive(1, 8'b01_100_100, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
      // JMP enters; EX and WB both target r4 while ADD r4,r4 decodes
      drive(1, 8'hC3, 1, 3'd4, 8'h11, 1, 3'd4, 8'h22);
      // MOV r4,r4 enters; JMP decoded as bubble
      drive(1, 8'b00_100_100, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
      // mid-stream reset with a WB write to r5 that must be dropped
      drive(0, 8'h6D, 0, 3'd0, 8'h00, 1, 3'd5, 8'h77);
      // MOV r5,r5 enters
      drive(1, 8'b00_101_101, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
      drive(1, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 39) != 0),
               8'($urandom()),
               1'($urandom_range(0, 2) == 0), 3'($urandom()), 8'($urandom()),
               1'($urandom_range(0, 1)), 3'($urandom()), 8'($urandom()));
      end
      drive(1, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
      guard = 0;
      while (sb_q.size() > 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      drive_done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter: DATA_W, 8, datapath and instruction width.
REQ-002 Parameter: NREG, 8, register-file entries (3-bit register index).
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 Port: instruc_code  input  8  instruction from fetch stage for the current PC.
REQ-006 Port: ex_we  input  1  instruction now in EX writes a register.
REQ-007 Port: ex_rd  input  3  destination index of instruction now in EX.
REQ-008 Port: ex_result  input  8  EX-stage result value (forwarding source).
REQ-009 Port: wb_we  input  1  WB-stage register write enable.
REQ-010 Port: wb_rd  input  3  WB destination index.
REQ-011 Port: wb_data  input  8  WB write data.
REQ-012 Port: idex_op  output  2  registered opcode to EX.
REQ-013 Port: idex_rd  output  3  registered destination index.
REQ-014 Port: idex_a  output  8  registered operand A (current value of rd).
REQ-015 Port: idex_b  output  8  registered operand B (rs value or immediate).
REQ-016 Port: idex_we  output  1  registered register-write enable for downstream.

Function
REQ-017 Instruction fields: op=[7:6], rd=[5:3], rs/imm=[2:0]; op 00 MOV, 01 ADD, 10 LDI, 11 JMP.
REQ-018 IF/ID register SHALL capture instruc_code every rising edge; ID/EX outputs SHALL update on the following edge (2-edge latency from instruc_code to idex_*).
REQ-019 MOV/ADD: idex_a=value(rd), idex_b=value(rs), idex_we=1, idex_rd=rd.
REQ-020 LDI: idex_a=value(rd), idex_b={5'b0,imm}, idex_we=1.
REQ-021 JMP: taken by fetch; decode SHALL emit idex_op=11, idex_rd=0, idex_a=0, idex_b=0, idex_we=0 (bubble-equivalent).
REQ-022 Operand value(r) priority: ex_result if ex_we and ex_rd==r; else wb_data if wb_we and wb_rd==r; else register file.
REQ-023 rd and rs reads SHALL resolve forwarding independently; rd==rs SHALL give identical A and B.
REQ-024 Register file: 8x8, one write port (wb_*), written on rising edge when wb_we=1; two combinational read ports.
REQ-025 Register r0 SHALL be an ordinary writable register.
REQ-026 No stall or flush inputs; one instruction accepted per cycle, no back-pressure.
REQ-027 ADD arithmetic is EX's responsibility; this block performs no arithmetic beyond zero-extension.

Reset
REQ-028 While rst=0 at a rising edge: IF/ID register cleared to 8'h00, all idex_* outputs cleared to 0, all register-file entries cleared to 0.
REQ-029 A cleared IF/ID (8'h00 = MOV r0,r0) SHALL still decode with idex_we=0 in the first cycle after reset (valid bit cleared by reset, set on first non-reset edge).
REQ-030 Reset asserted mid-stream SHALL discard the in-flight instruction and ignore any wb_we write at that edge.

Structure
REQ-031 Shared package SHALL hold opcode constants (OP_MOV, OP_ADD, OP_LDI, OP_JMP) and field bit positions, also used by fetch and EX.
REQ-032 One sub-module: regfile (8x8, 2R/1W, synchronous active-low clear); forwarding muxes and pipeline registers stay in id_stage.

Verification
REQ-033 Reset: hold rst=0 two cycles, instruc_code=8'h5A -> all idex_*=0; first post-reset cycle idex_we=0.
REQ-034 LDI: instruc_code=8'b10_011_101 -> two edges later idex_op=10, idex_rd=3, idex_b=8'h05, idex_we=1.
REQ-035 WB bypass: regfile r2=0, wb_we=1, wb_rd=2, wb_data=8'h33 same cycle as MOV r1,r2 in ID -> idex_b=8'h33; r2 reads 8'h33 afterwards.
REQ-036 Priority: ex_we=1/ex_rd=4/ex_result=8'h11 and wb_we=1/wb_rd=4/wb_data=8'h22 while ADD r4,r4 in ID -> idex_a=idex_b=8'h11.
REQ-037 JMP: instruc_code=8'hC3 -> idex_op=11, idex_we=0, idex_a=idex_b=0; regfile unchanged.
REQ-038 Reset mid-operation: rst=0 for one edge with wb_we=1, wb_rd=5 -> r5 remains 0 and idex_* cleared.
